// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 encodings, FSM state
// type, legality and misalignment checks, lane selection and store replication.
// Pure declarations; no logic of its own.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    // Unsigned widths exist only for loads; a "store unsigned" is illegal.
    function automatic logic f3_legal(input logic [2:0] f3, input logic write);
        case (f3)
            F3_B, F3_H, F3_W: f3_legal = 1'b1;
            F3_BU, F3_HU:     f3_legal = ~write;
            default:          f3_legal = 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_H, F3_HU: misaligned = lo[0];
            F3_W:        misaligned = |lo;
            default:     misaligned = 1'b0;
        endcase
    endfunction

    // Byte offset actually used for lane choice: address bits below the
    // access size are dropped, so a misaligned access snaps to its natural lane.
    function automatic logic [1:0] lane_off(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_B, F3_BU: lane_off = lo;
            F3_H, F3_HU: lane_off = {lo[1], 1'b0};
            default:     lane_off = 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B, F3_BU: lane_be = 4'b0001 << off;
            F3_H, F3_HU: lane_be = off[1] ? 4'b1100 : 4'b0011;
            default:     lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_rep(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            F3_B:    store_rep = {4{d[7:0]}};
            F3_H:    store_rep = {2{d[15:0]}};
            default: store_rep = d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load formatter: shifts the raw memory word down to the addressed lane and
// sign- or zero-extends it according to funct3. Purely combinational.
// Ports: mem_rdata (raw word), addr_lo (lane offset), f3 (width/sign), rdata (result).
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  f3,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    always_comb begin
        shifted = mem_rdata >> {addr_lo, 3'b000};
        case (f3)
            F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   rdata = {24'b0, shifted[7:0]};
            F3_HU:   rdata = {16'b0, shifted[15:0]};
            default: rdata = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one RV32I load/store per transaction onto a word memory port.
// Latency: accept edge N -> mem_req in N+1 -> zero-wait ack gives rsp_valid in N+2;
// next accept at N+3. Backpressure: req_ready only in IDLE, core stalls on busy.
// Optional LSU_MISALIGN_TRAP_EN: misaligned requests error out without touching memory.
// Ports: req_* (core request, valid/ready), rsp_* (one-cycle response pulse),
// busy, mem_* (word-addressed memory port, held until mem_ack or timeout).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_f3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_en,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [2:0]  f3_q, f3_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_error_q, rsp_error_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        busy_q, busy_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_byte_en_q, mem_byte_en_d;

    logic [31:0] load_word;
    logic        trap;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = misaligned(req_f3, req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    lsu_load_align u_align (
        .mem_rdata (mem_rdata),
        .addr_lo   (addr_lo_q),
        .f3        (f3_q),
        .rdata     (load_word)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_lo_d     = addr_lo_q;
        f3_d          = f3_q;
        busy_d        = busy_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_byte_en_d = mem_byte_en_q;
        // Response fields are only ever non-zero for the single RESP cycle.
        rsp_valid_d   = 1'b0;
        rsp_error_d   = 1'b0;
        rsp_rdata_d   = 32'd0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    busy_d    = 1'b1;
                    f3_d      = req_f3;
                    addr_lo_d = lane_off(req_f3, req_addr[1:0]);
                    if (!f3_legal(req_f3, req_write) || trap) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_error_d = 1'b1;
                    end else begin
                        state_d       = ACCESS;
                        cnt_d         = 8'd0;
                        mem_req_d     = 1'b1;
                        mem_we_d      = req_write;
                        mem_addr_d    = {req_addr[31:2], 2'b00};
                        mem_byte_en_d = lane_be(req_f3, lane_off(req_f3, req_addr[1:0]));
                        mem_wdata_d   = store_rep(req_f3, req_wdata);
                    end
                end
            end
            ACCESS: begin
                // Ack wins over the timeout when both land in the same cycle.
                if (mem_ack) begin
                    state_d       = RESP;
                    mem_req_d     = 1'b0;
                    mem_we_d      = 1'b0;
                    mem_byte_en_d = 4'b0000;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = mem_we_q ? 32'd0 : load_word;
                end else if (cnt_q == TO_LAST) begin
                    state_d       = RESP;
                    mem_req_d     = 1'b0;
                    mem_we_d      = 1'b0;
                    mem_byte_en_d = 4'b0000;
                    rsp_valid_d   = 1'b1;
                    rsp_error_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                cnt_d   = 8'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            addr_lo_q     <= 2'b00;
            f3_q          <= 3'b000;
            rsp_valid_q   <= 1'b0;
            rsp_error_q   <= 1'b0;
            rsp_rdata_q   <= 32'd0;
            busy_q        <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 32'd0;
            mem_wdata_q   <= 32'd0;
            mem_byte_en_q <= 4'b0000;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_lo_q     <= addr_lo_d;
            f3_q          <= f3_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_error_q   <= rsp_error_d;
            rsp_rdata_q   <= rsp_rdata_d;
            busy_q        <= busy_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_byte_en_q <= mem_byte_en_d;
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_error   = rsp_error_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign busy        = busy_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_byte_en = mem_byte_en_q;

endmodule
